// File: rtl/mips_pkg.sv
// Shared constants and types for the multi-cycle MIPS core.
// Opcodes, ALU ops, mem modes, FSM states, trap causes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_OR  = 4'h1;
  localparam logic [3:0] ALU_ADD = 4'h2;
  localparam logic [3:0] ALU_SUB = 4'h6;
  localparam logic [3:0] ALU_SLT = 4'h7;
  localparam logic [3:0] ALU_SLL = 4'h8;
  localparam logic [3:0] ALU_SRL = 4'h9;
  localparam logic [3:0] ALU_LUI = 4'hA;

  localparam logic [2:0] MM_WORD  = 3'd0;
  localparam logic [2:0] MM_HALF  = 3'd1;
  localparam logic [2:0] MM_HALFU = 3'd2;
  localparam logic [2:0] MM_BYTE  = 3'd3;
  localparam logic [2:0] MM_BYTEU = 3'd4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_R,
    ST_EXEC_I,
    ST_MEM_ADDR,
    ST_MEM_RD,
    ST_MEM_WB,
    ST_MEM_WR,
    ST_WB_R,
    ST_WB_I,
    ST_BRANCH,
    ST_JUMP,
    ST_TRAP
  } state_t;

  typedef enum logic [1:0] {
    TC_NONE    = 2'd0,
    TC_ILLEGAL = 2'd1,
    TC_TIMEOUT = 2'd2
  } cause_t;

  function automatic logic is_load(
    input logic [5:0] op
  );
    return (op == OP_LB)  || (op == OP_LH) ||
           (op == OP_LW)  || (op == OP_LBU) ||
           (op == OP_LHU);
  endfunction

  function automatic logic is_store(
    input logic [5:0] op
  );
    return (op == OP_SB) || (op == OP_SH) ||
           (op == OP_SW);
  endfunction

  function automatic logic is_itype(
    input logic [5:0] op
  );
    return (op == OP_ADDI) || (op == OP_SLTI) ||
           (op == OP_ANDI) || (op == OP_ORI) ||
           (op == OP_LUI);
  endfunction

  // Logical immediates take the zero-extended operand
  function automatic logic zext_imm(
    input logic [5:0] op
  );
    return (op == OP_ANDI) || (op == OP_ORI) ||
           (op == OP_LUI);
  endfunction

  function automatic logic [2:0] mem_mode_of(
    input logic [5:0] op
  );
    logic [2:0] m;
    case (op)
      OP_LH, OP_SH: m = MM_HALF;
      OP_LHU:       m = MM_HALFU;
      OP_LB, OP_SB: m = MM_BYTE;
      OP_LBU:       m = MM_BYTEU;
      default:      m = MM_WORD;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mips_mc_alu_decode.sv
// Combinational opcode/funct to ALU op decode.
// Flags unsupported funct (R-type) or opcode.
module mips_mc_alu_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       illegal
);

  // ALU op select and legality check
  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    if (opcode == OP_RTYPE) begin
      unique case (funct)
        FN_ADD:  alu_op = ALU_ADD;
        FN_SUB:  alu_op = ALU_SUB;
        FN_AND:  alu_op = ALU_AND;
        FN_OR:   alu_op = ALU_OR;
        FN_SLT:  alu_op = ALU_SLT;
        FN_SLL:  alu_op = ALU_SLL;
        FN_SRL:  alu_op = ALU_SRL;
        FN_JR:   alu_op = ALU_ADD;
        default: illegal = 1'b1;
      endcase
    end else begin
      unique case (opcode)
        OP_ADDI: alu_op = ALU_ADD;
        OP_SLTI: alu_op = ALU_SLT;
        OP_ANDI: alu_op = ALU_AND;
        OP_ORI:  alu_op = ALU_OR;
        OP_LUI:  alu_op = ALU_LUI;
        OP_LB, OP_LH, OP_LW,
        OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW:
          alu_op = ALU_ADD;
        OP_BEQ, OP_BNE:
          alu_op = ALU_SUB;
        OP_J, OP_JAL:
          alu_op = ALU_ADD;
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM with memory waits and traps.
// Define MIPS_MC_PERF_EN for cycle/instr/wait perf counters.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int MODE_W      = 3
`ifdef MIPS_MC_PERF_EN
  ,
  parameter int PERF_W      = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic              zero_flag,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic              iord,
  output logic [MODE_W-1:0] mem_mode,
  output logic              ir_write,
  output logic              pc_write,
  output logic [1:0]        pcsrc,
  output logic              reg_write,
  output logic [1:0]        regdst,
  output logic [1:0]        memtoreg,
  output logic              alusrc_a,
  output logic [1:0]        alusrc_b,
  output logic [3:0]        alu_control_line,
  output logic              instr_done,
  output logic              trap,
  output logic [1:0]        trap_cause
`ifdef MIPS_MC_PERF_EN
  ,
  output logic [PERF_W-1:0] cycle_count,
  output logic [PERF_W-1:0] instr_count,
  output logic [PERF_W-1:0] wait_count
`endif
);

  localparam int TMO_LAST =
    (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam int WCW =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t         state;
  state_t         state_nxt;
  cause_t         cause;
  cause_t         cause_nxt;
  logic [WCW-1:0] wait_cnt;
  logic [3:0]     dec_alu;
  logic           dec_ill;
  logic           in_mem;
  logic           tmo;
  logic           is_jr;
  logic [MODE_W-1:0] mode;

  mips_mc_alu_decode u_dec (
    .opcode  (opcode),
    .funct   (funct),
    .alu_op  (dec_alu),
    .illegal (dec_ill)
  );

  assign in_mem = (state == ST_FETCH) ||
                  (state == ST_MEM_RD) ||
                  (state == ST_MEM_WR);
  assign tmo = (MEM_TIMEOUT != 0) && in_mem &&
               !mem_ready &&
               (wait_cnt == WCW'(TMO_LAST));
  assign is_jr = (opcode == OP_RTYPE) &&
                 (funct == FN_JR);
  assign mode = MODE_W'(mem_mode_of(opcode));
  assign trap_cause = cause;

  // Next-state and trap-cause selection
  always_comb begin
    state_nxt = state;
    cause_nxt = cause;
    case (state)
      ST_IDLE: state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready) begin
          state_nxt = ST_DECODE;
        end else if (tmo) begin
          state_nxt = ST_TRAP;
          cause_nxt = TC_TIMEOUT;
        end
      end
      ST_DECODE: begin
        unique case (1'b1)
          (opcode == OP_RTYPE):
            state_nxt = ST_EXEC_R;
          is_itype(opcode):
            state_nxt = ST_EXEC_I;
          is_load(opcode) || is_store(opcode):
            state_nxt = ST_MEM_ADDR;
          (opcode == OP_BEQ) || (opcode == OP_BNE):
            state_nxt = ST_BRANCH;
          (opcode == OP_J) || (opcode == OP_JAL):
            state_nxt = ST_JUMP;
          default: begin
            state_nxt = ST_TRAP;
            cause_nxt = TC_ILLEGAL;
          end
        endcase
      end
      ST_EXEC_R: begin
        if (dec_ill) begin
          state_nxt = ST_TRAP;
          cause_nxt = TC_ILLEGAL;
        end else if (is_jr) begin
          state_nxt = ST_FETCH;
        end else begin
          state_nxt = ST_WB_R;
        end
      end
      ST_EXEC_I: state_nxt = ST_WB_I;
      ST_MEM_ADDR:
        state_nxt = is_store(opcode) ?
                    ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: begin
        if (mem_ready) begin
          state_nxt = ST_MEM_WB;
        end else if (tmo) begin
          state_nxt = ST_TRAP;
          cause_nxt = TC_TIMEOUT;
        end
      end
      ST_MEM_WR: begin
        if (mem_ready) begin
          state_nxt = ST_FETCH;
        end else if (tmo) begin
          state_nxt = ST_TRAP;
          cause_nxt = TC_TIMEOUT;
        end
      end
      ST_WB_R, ST_WB_I, ST_MEM_WB,
      ST_BRANCH, ST_JUMP:
        state_nxt = ST_FETCH;
      ST_TRAP: state_nxt = ST_TRAP;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, sticky cause and per-request wait counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cause    <= TC_NONE;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      cause <= cause_nxt;
      if (state_nxt != state) begin
        wait_cnt <= '0;
      end else if (in_mem && !mem_ready) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // Moore output decode, enables qualified where needed
  always_comb begin
    mem_req          = 1'b0;
    mem_we           = 1'b0;
    iord             = 1'b0;
    mem_mode         = '0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    pcsrc            = 2'd0;
    reg_write        = 1'b0;
    regdst           = 2'd0;
    memtoreg         = 2'd0;
    alusrc_a         = 1'b0;
    alusrc_b         = 2'd0;
    alu_control_line = ALU_AND;
    instr_done       = 1'b0;
    trap             = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req          = 1'b1;
        alusrc_b         = 2'd1;
        alu_control_line = ALU_ADD;
        ir_write         = mem_ready;
        pc_write         = mem_ready;
      end
      ST_DECODE: begin
        alusrc_b         = 2'd2;
        alu_control_line = ALU_ADD;
      end
      ST_EXEC_R: begin
        alusrc_a         = 1'b1;
        alu_control_line = dec_alu;
        if (is_jr) begin
          pc_write   = 1'b1;
          pcsrc      = 2'd3;
          instr_done = 1'b1;
        end
      end
      ST_EXEC_I: begin
        alusrc_a         = 1'b1;
        alusrc_b         = zext_imm(opcode) ?
                           2'd3 : 2'd2;
        alu_control_line = dec_alu;
      end
      ST_WB_R: begin
        reg_write  = 1'b1;
        regdst     = 2'd1;
        instr_done = 1'b1;
      end
      ST_WB_I: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      ST_MEM_ADDR: begin
        alusrc_a         = 1'b1;
        alusrc_b         = 2'd2;
        alu_control_line = ALU_ADD;
        mem_mode         = mode;
      end
      ST_MEM_RD: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        mem_mode = mode;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        memtoreg   = 2'd1;
        mem_mode   = mode;
        instr_done = 1'b1;
      end
      ST_MEM_WR: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        iord       = 1'b1;
        mem_mode   = mode;
        instr_done = mem_ready;
      end
      ST_BRANCH: begin
        alusrc_a         = 1'b1;
        alu_control_line = ALU_SUB;
        pcsrc            = 2'd1;
        pc_write   = ((opcode == OP_BEQ) && zero_flag) ||
                     ((opcode == OP_BNE) && !zero_flag);
        instr_done = 1'b1;
      end
      ST_JUMP: begin
        pc_write   = 1'b1;
        pcsrc      = 2'd2;
        instr_done = 1'b1;
        if (opcode == OP_JAL) begin
          reg_write = 1'b1;
          regdst    = 2'd2;
          memtoreg  = 2'd2;
        end
      end
      ST_TRAP: trap = 1'b1;
      default: ;
    endcase
  end

`ifdef MIPS_MC_PERF_EN
  // Free-running perf counters, wrap silently
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
      instr_count <= '0;
      wait_count  <= '0;
    end else begin
      if (state != ST_IDLE && state != ST_TRAP)
        cycle_count <= cycle_count + 1'b1;
      if (instr_done)
        instr_count <= instr_count + 1'b1;
      if (mem_req && !mem_ready)
        wait_count <= wait_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: vector table
// plus trap, timeout and mid-access reset sequences.
module tb_mips_mc_ctrl;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero_flag;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic [2:0] mem_mode;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pcsrc;
  logic       reg_write;
  logic [1:0] regdst;
  logic [1:0] memtoreg;
  logic       alusrc_a;
  logic [1:0] alusrc_b;
  logic [3:0] alu_control_line;
  logic       instr_done;
  logic       trap;
  logic [1:0] trap_cause;

  int nvec = 0;
  int nerr = 0;

  mips_mc_ctrl #(
    .MEM_TIMEOUT (16),
    .MODE_W      (3)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .opcode           (opcode),
    .funct            (funct),
    .zero_flag        (zero_flag),
    .mem_ready        (mem_ready),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .iord             (iord),
    .mem_mode         (mem_mode),
    .ir_write         (ir_write),
    .pc_write         (pc_write),
    .pcsrc            (pcsrc),
    .reg_write        (reg_write),
    .regdst           (regdst),
    .memtoreg         (memtoreg),
    .alusrc_a         (alusrc_a),
    .alusrc_b         (alusrc_b),
    .alu_control_line (alu_control_line),
    .instr_done       (instr_done),
    .trap             (trap),
    .trap_cause       (trap_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         waits;
    int         cyc;
    logic [2:0] mode;
    logic       pcw;
    logic [1:0] pcs;
    logic       rw;
    logic [1:0] rd;
    logic [1:0] mtr;
  } vec_t;

  vec_t tv[$];

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input string n, input logic [5:0] op,
    input logic [5:0] fn, input logic z,
    input int w, input int c, input logic [2:0] m,
    input logic pcw, input logic [1:0] pcs,
    input logic rw, input logic [1:0] rd,
    input logic [1:0] mtr
  );
    vec_t v;
    v.name = n;  v.op = op;   v.fn = fn;
    v.z = z;     v.waits = w; v.cyc = c;
    v.mode = m;  v.pcw = pcw; v.pcs = pcs;
    v.rw = rw;   v.rd = rd;   v.mtr = mtr;
    return v;
  endfunction

  // Start a new instruction just after FETCH is entered
  task automatic start(
    input logic [5:0] op,
    input logic [5:0] fn,
    input logic       z
  );
    @(posedge clk);
    #1;
    opcode    = op;
    funct     = fn;
    zero_flag = z;
  endtask

  task automatic run(input vec_t v);
    int cyc = 0;
    int wc = 0;
    bit done = 0;
    start(v.op, v.fn, v.z);
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (mem_req && iord) begin
        mem_ready = (wc >= v.waits);
        if (!mem_ready) wc++;
      end else begin
        mem_ready = 1'b1;
      end
      #1;
      if (cyc == 1) begin
        check({v.name, ".fetch"},
              {mem_req, iord, alusrc_b,
               ir_write, pc_write},
              {1'b1, 1'b0, 2'd1, 1'b1, 1'b1});
        check({v.name, ".fetch_alu"},
              alu_control_line, ALU_ADD);
      end
      if (mem_req && iord && !mem_ready)
        check({v.name, ".mode_hold"},
              mem_mode, v.mode);
      if (instr_done) begin
        done = 1;
        check({v.name, ".cycles"}, cyc, v.cyc);
        check({v.name, ".pc_write"},
              pc_write, v.pcw);
        check({v.name, ".pcsrc"}, pcsrc, v.pcs);
        check({v.name, ".reg_write"},
              reg_write, v.rw);
        check({v.name, ".regdst"}, regdst, v.rd);
        check({v.name, ".memtoreg"},
              memtoreg, v.mtr);
      end
    end
    check({v.name, ".done_seen"}, done, 1);
  endtask

  // Run an instruction that must end in TRAP
  task automatic run_trap(
    input string      name,
    input logic [5:0] op,
    input logic [5:0] fn,
    input int         exp_cyc,
    input int         exp_waits,
    input logic [1:0] exp_cause
  );
    int cyc = 0;
    int waits = 0;
    start(op, fn, 1'b0);
    while (!trap && cyc < 60) begin
      @(negedge clk);
      cyc++;
      mem_ready = !(mem_req && iord);
      #1;
      if (mem_req && iord) waits++;
    end
    check({name, ".cycles"}, cyc, exp_cyc);
    check({name, ".waits"}, waits, exp_waits);
    check({name, ".trap"}, trap, 1'b1);
    check({name, ".cause"}, trap_cause, exp_cause);
    check({name, ".enables"},
          {mem_req, mem_we, pc_write, ir_write,
           reg_write, instr_done}, 0);
    @(negedge clk);
    #1;
    check({name, ".sticky"},
          {trap, trap_cause}, {1'b1, exp_cause});
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check({name, ".rst_trap"},
          {trap, trap_cause}, 0);
    check({name, ".rst_en"},
          {mem_req, pc_write, ir_write,
           reg_write, instr_done}, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit hit");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    opcode    = 6'h00;
    funct     = 6'h20;
    zero_flag = 1'b0;
    mem_ready = 1'b0;

    tv.push_back(mk("add",  6'h00, 6'h20, 0, 0, 4, 0, 0, 0, 1, 1, 0));
    tv.push_back(mk("sub",  6'h00, 6'h22, 0, 0, 4, 0, 0, 0, 1, 1, 0));
    tv.push_back(mk("sll",  6'h00, 6'h00, 0, 0, 4, 0, 0, 0, 1, 1, 0));
    tv.push_back(mk("slt",  6'h00, 6'h2A, 0, 0, 4, 0, 0, 0, 1, 1, 0));
    tv.push_back(mk("jr",   6'h00, 6'h08, 0, 0, 3, 0, 1, 3, 0, 0, 0));
    tv.push_back(mk("addi", 6'h08, 6'h00, 0, 0, 4, 0, 0, 0, 1, 0, 0));
    tv.push_back(mk("lui",  6'h0F, 6'h00, 0, 0, 4, 0, 0, 0, 1, 0, 0));
    tv.push_back(mk("ori",  6'h0D, 6'h00, 0, 0, 4, 0, 0, 0, 1, 0, 0));
    tv.push_back(mk("lw0",  6'h23, 6'h00, 0, 0, 5, 0, 0, 0, 1, 0, 1));
    tv.push_back(mk("lw3",  6'h23, 6'h00, 0, 3, 8, 0, 0, 0, 1, 0, 1));
    tv.push_back(mk("lhu1", 6'h25, 6'h00, 0, 1, 6, 2, 0, 0, 1, 0, 1));
    tv.push_back(mk("lb",   6'h20, 6'h00, 0, 0, 5, 3, 0, 0, 1, 0, 1));
    tv.push_back(mk("sw",   6'h2B, 6'h00, 0, 0, 4, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk("sh2",  6'h29, 6'h00, 0, 2, 6, 1, 0, 0, 0, 0, 0));
    tv.push_back(mk("beq_t",6'h04, 6'h00, 1, 0, 3, 0, 1, 1, 0, 0, 0));
    tv.push_back(mk("beq_n",6'h04, 6'h00, 0, 0, 3, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk("bne_z",6'h05, 6'h00, 1, 0, 3, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk("bne_t",6'h05, 6'h00, 0, 0, 3, 0, 1, 1, 0, 0, 0));
    tv.push_back(mk("j",    6'h02, 6'h00, 0, 0, 3, 0, 1, 2, 0, 0, 0));
    tv.push_back(mk("jal",  6'h03, 6'h00, 0, 0, 3, 0, 1, 2, 1, 2, 2));

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset.outs",
          {mem_req, mem_we, iord, mem_mode, ir_write,
           pc_write, pcsrc, reg_write, regdst,
           memtoreg, alusrc_a, alusrc_b,
           instr_done, trap}, 0);
    check("reset.cause", trap_cause, 0);
    reset = 1'b0;

    foreach (tv[i]) run(tv[i]);

    run_trap("illegal_op", 6'h3F, 6'h00, 3, 0, 2'd1);
    do_reset("rst1");
    run_trap("illegal_fn", 6'h00, 6'h3F, 4, 0, 2'd1);
    do_reset("rst2");
    run_trap("sb_timeout", 6'h28, 6'h00, 20, 16, 2'd2);
    do_reset("rst3");

    begin
      int cyc = 0;
      start(6'h2B, 6'h00, 1'b0);
      while (!mem_we && cyc < 20) begin
        @(negedge clk);
        cyc++;
        mem_ready = !(mem_req && iord);
        #1;
      end
      check("midwr.reach", {mem_we, cyc}, {1'b1, 32'd4});
      #2;
      reset = 1'b1;
      #1;
      check("midwr.drop",
            {mem_req, mem_we, iord, instr_done}, 0);
      @(negedge clk);
      reset = 1'b0;
      run(tv[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
